// File: rtl/softmax_max_sub_pkg.sv
// softmax_max_sub_pkg: fixed-point format, saturation limits and FSM encoding shared by the softmax stages.
// Revision: 1.0
`default_nettype none

package softmax_max_sub_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int FRACTION_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/softmax_row_buf.sv
// softmax_row_buf: simple dual-port RAM, synchronous write, registered read, no reset on contents.
// Revision: 1.0
`default_nettype none

module softmax_row_buf #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  import softmax_max_sub_pkg::*;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/softmax_max_sub.sv
// softmax_max_sub: buffers one score row, tracks its maximum, then streams saturated (x - row_max).
// Revision: 1.0
`default_nettype none

module softmax_max_sub #(
  parameter int DATA_WIDTH = softmax_max_sub_pkg::DATA_WIDTH,
  parameter int ROW_LEN    = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_clear,
  output logic                  o_exp_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_row_max
);

  import softmax_max_sub_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ROW_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_wr_cnt;
  logic [ADDR_WIDTH-1:0]   r_rd_cnt;
  logic [DATA_WIDTH-1:0]   r_max;
  logic [DATA_WIDTH-1:0]   w_ram_q;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_vld1;
  logic                    r_vld2;
  logic                    r_last1;
  logic                    r_last2;
  logic                    w_xfer;
  logic                    w_rd_en;
  logic [DATA_WIDTH:0]     w_diff;
  logic [DATA_WIDTH-1:0]   w_diff_sat;

  assign o_ready = (r_state == COLLECT);
  assign w_xfer  = i_valid & o_ready & ~i_clear;
  assign w_rd_en = (r_state == DRAIN) & ~i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_xfer && r_wr_cnt == LAST_IDX) w_state_nxt = DRAIN;
        DRAIN:   if (r_rd_cnt == LAST_IDX) w_state_nxt = COLLECT;
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  // First element of a row seeds the max so all-negative rows are handled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_max    <= '0;
    end else if (i_clear) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_wr_cnt <= (r_wr_cnt == LAST_IDX) ? '0 : r_wr_cnt + 1'b1;
        if (r_wr_cnt == '0 || $signed(i_data) > $signed(r_max)) begin
          r_max <= i_data;
        end
      end
      if (w_rd_en) begin
        r_rd_cnt <= (r_rd_cnt == LAST_IDX) ? '0 : r_rd_cnt + 1'b1;
      end
    end
  end

  softmax_row_buf #(
    .DEPTH      (ROW_LEN),
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_row_buf (
    .clk       (clk),
    .i_wr_en   (w_xfer),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data (i_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_cnt),
    .o_rd_data (w_ram_q)
  );

  // Extended by one bit; only negative overflow is reachable since row_max >= x.
  assign w_diff     = {r_rd_data[DATA_WIDTH-1], r_rd_data} - {o_row_max[DATA_WIDTH-1], o_row_max};
  assign w_diff_sat = (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1]) ? SAT_MIN : w_diff[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1    <= 1'b0;
      r_vld2    <= 1'b0;
      r_last1   <= 1'b0;
      r_last2   <= 1'b0;
      r_rd_data <= '0;
      o_exp_en  <= 1'b0;
      o_last    <= 1'b0;
      o_data    <= '0;
      o_row_max <= '0;
    end else if (i_clear) begin
      r_vld1   <= 1'b0;
      r_vld2   <= 1'b0;
      r_last1  <= 1'b0;
      r_last2  <= 1'b0;
      o_exp_en <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      r_vld1    <= w_rd_en;
      r_last1   <= w_rd_en & (r_rd_cnt == LAST_IDX);
      r_vld2    <= r_vld1;
      r_last2   <= r_last1;
      r_rd_data <= w_ram_q;
      o_exp_en  <= r_vld2;
      o_last    <= r_last2;
      if (r_vld2) begin
        o_data <= w_diff_sat;
      end
      if (r_state == DRAIN && r_rd_cnt == '0) begin
        o_row_max <= r_max;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
// tb_softmax_max_sub: directed rows with hand-computed differences, queue scoreboard checked by a negedge monitor.
// Revision: 1.0
`default_nettype none

module tb_softmax_max_sub;

  localparam int DW = 32;

  typedef logic [DW-1:0] row_t [4];
  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [DW-1:0] m;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          i_clear;
  logic          o_exp_en;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [DW-1:0] o_row_max;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   ignore_out = 0;

  softmax_max_sub #(
    .DATA_WIDTH (DW),
    .ROW_LEN    (4),
    .ADDR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .i_clear   (i_clear),
    .o_exp_en  (o_exp_en),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_row_max (o_row_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_exp_en && !ignore_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL spurious_exp_en: got o_data=%h, required no output", o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("o_data", o_data, e.d);
        chk("o_last", {31'd0, o_last}, {31'd0, e.l});
        chk("o_row_max", o_row_max, e.m);
      end
    end
  end

  task automatic send_row(input row_t v, input row_t d, input logic [DW-1:0] mx,
                          input bit push, output int stalls);
    stalls = 0;
    if (push) begin
      for (int i = 0; i < 4; i++) sb.push_back({d[i], (i == 3), mx});
    end
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      i_data  = v[i];
      while (!o_ready && stalls < 100) begin
        @(posedge clk); #1;
        stalls++;
      end
      if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  row_t v, d;
  int   st;

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_clear = 1'b0;
    #1;
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_o_exp_en", {31'd0, o_exp_en}, 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_o_last", {31'd0, o_last}, 32'd0);
    chk("rst_o_row_max", o_row_max, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Row 1: latency and exp_en window after the last accept
    v = '{32'd5, -32'sd3, 32'd12, 32'd12};
    d = '{-32'sd7, -32'sd15, 32'd0, 32'd0};
    send_row(v, d, 32'd12, 1'b1, st);
    i_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("exp_en_edge_E+%0d", k), {31'd0, o_exp_en}, {31'd0, (k >= 3 && k <= 6)});
    end
    idle(3);

    // Row 2: all negative
    v = '{-32'sd100, -32'sd200, -32'sd50, -32'sd400};
    d = '{-32'sd50, -32'sd150, 32'd0, -32'sd350};
    send_row(v, d, -32'sd50, 1'b1, st);
    idle(10);

    // Row 3: saturation at the negative limit
    v = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h1};
    d = '{32'h0, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002};
    send_row(v, d, 32'h7FFF_FFFF, 1'b1, st);
    idle(10);

    // Rows 4 and 5 back to back with i_valid held high
    v = '{32'd10, 32'd20, 32'd30, 32'd40};
    d = '{-32'sd30, -32'sd20, -32'sd10, 32'd0};
    send_row(v, d, 32'd40, 1'b1, st);
    v = '{-32'sd1, 32'd8, 32'd2, 32'd8};
    d = '{-32'sd9, 32'd0, -32'sd6, 32'd0};
    send_row(v, d, 32'd8, 1'b1, st);
    chk("ready_low_between_rows", st, 32'd4);
    idle(10);

    // Aborted row; clear coincides with a valid element that must be dropped
    v = '{32'd9, 32'd9, 32'd0, 32'd0};
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_data  = v[i];
      @(posedge clk); #1;
    end
    i_clear = 1'b1;
    i_data  = 32'd77;
    @(posedge clk); #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    @(posedge clk); #1;
    v = '{32'd1, 32'd2, 32'd3, 32'd4};
    d = '{-32'sd3, -32'sd2, -32'sd1, 32'd0};
    send_row(v, d, 32'd4, 1'b1, st);
    idle(10);

    // Async reset while the row is draining
    ignore_out = 1'b1;
    v = '{32'd1, 32'd1, 32'd1, 32'd1};
    send_row(v, d, 32'd1, 1'b0, st);
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("exp_en_before_reset", {31'd0, o_exp_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("exp_en_in_reset", {31'd0, o_exp_en}, 32'd0);
    chk("data_in_reset", o_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ignore_out = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, o_ready}, 32'd1);
    v = '{32'd100, 32'd50, -32'sd25, 32'd75};
    d = '{32'd0, -32'sd50, -32'sd125, -32'sd25};
    send_row(v, d, 32'd100, 1'b1, st);
    i_valid = 1'b0;

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
